// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-issue instruction fetch controller.
// Drives the ROM address from the PC, registers the returned word with a
// one-cycle latency, handles branch flush, stall hold and halt detection,
// and counts the cycles spent running since the last Start.
module fetch_ctrl #(
  parameter int A = 10,
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Stall,
  input  logic         BranchEn,
  input  logic [A-1:0] BranchTarget,
  input  logic [W-1:0] InstIn,
  output logic [A-1:0] InstAddress,
  output logic [W-1:0] Inst,
  output logic [A-1:0] InstPC,
  output logic         InstValid,
  output logic         Done,
  output logic [15:0]  CycleCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [W-1:0] HALT_WORD = {W{1'b1}};
  localparam logic [15:0]  COUNT_MAX = 16'hFFFF;

  state_t       state;
  logic [A-1:0] pc;
  logic         is_halt_word;

  // The ROM address is the PC register itself, with no logic on the path.
  assign InstAddress  = pc;
  assign is_halt_word = (InstIn == HALT_WORD);

  // Control FSM together with the PC, fetch register and cycle counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      pc         <= '0;
      Inst       <= '0;
      InstPC     <= '0;
      InstValid  <= 1'b0;
      Done       <= 1'b0;
      CycleCount <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (Start) begin
            state      <= RUN;
            pc         <= '0;
            InstValid  <= 1'b0;
            Done       <= 1'b0;
            CycleCount <= '0;
          end
        end
        RUN: begin
          if (CycleCount != COUNT_MAX) begin
            CycleCount <= CycleCount + 16'd1;
          end
          if (BranchEn) begin
            pc        <= BranchTarget;
            InstValid <= 1'b0;
          end else if (Stall) begin
            pc        <= pc;
          end else if (is_halt_word) begin
            InstValid <= 1'b0;
            Done      <= 1'b1;
            state     <= HALT;
          end else begin
            Inst      <= InstIn;
            InstPC    <= pc;
            InstValid <= 1'b1;
            pc        <= pc + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed plus randomized checking of fetch_ctrl against a
// behavioural model of fetch, branch, stall, halt and cycle counting.
module tb_fetch_ctrl;

  localparam int A     = 10;
  localparam int W     = 9;
  localparam int DEPTH = 1 << A;
  localparam int HALTW = (1 << W) - 1;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic         Stall;
  logic         BranchEn;
  logic [A-1:0] BranchTarget;
  logic [W-1:0] InstIn;
  logic [A-1:0] InstAddress;
  logic [W-1:0] Inst;
  logic [A-1:0] InstPC;
  logic         InstValid;
  logic         Done;
  logic [15:0]  CycleCount;

  logic [W-1:0] rom [DEPTH];

  int checks = 0;
  int errors = 0;

  // Behavioural model of the controller
  bit           m_running;
  int           m_pc;
  int           m_ipc;
  int           m_cnt;
  int           m_inst;
  bit           m_valid;
  bit           m_done;

  fetch_ctrl #(.A(A), .W(W)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Stall(Stall),
    .BranchEn(BranchEn),
    .BranchTarget(BranchTarget),
    .InstIn(InstIn),
    .InstAddress(InstAddress),
    .Inst(Inst),
    .InstPC(InstPC),
    .InstValid(InstValid),
    .Done(Done),
    .CycleCount(CycleCount)
  );

  always #5 Clk = ~Clk;

  // The instruction ROM answers combinationally for the current address.
  assign InstIn = rom[InstAddress];

  task automatic fillRom(input int halt_pct);
    for (int i = 0; i < DEPTH; i++) begin
      if (halt_pct > 0 && $urandom_range(99, 0) < halt_pct)
        rom[i] = W'(HALTW);
      else
        rom[i] = W'($urandom_range(HALTW - 1, 0));
    end
  endtask

  task automatic modelReset();
    m_running = 0; m_pc = 0; m_ipc = 0; m_cnt = 0;
    m_inst = 0; m_valid = 0; m_done = 0;
  endtask

  // One rising edge of the model, using the inputs currently applied.
  task automatic modelStep();
    int word;
    if (!m_running) begin
      if (Start) begin
        m_running = 1; m_pc = 0; m_valid = 0; m_done = 0; m_cnt = 0;
      end
    end else begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      word  = int'(rom[m_pc]);
      if (BranchEn) begin
        m_pc    = int'(BranchTarget);
        m_valid = 0;
      end else if (Stall) begin
        // everything holds
      end else if (word == HALTW) begin
        m_valid   = 0;
        m_done    = 1;
        m_running = 0;
      end else begin
        m_inst  = word;
        m_ipc   = m_pc;
        m_valid = 1;
        m_pc    = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic cmp(input string tag, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp(tag, "InstAddress", 32'(InstAddress), 32'(m_pc));
    cmp(tag, "Inst",        32'(Inst),        32'(m_inst));
    cmp(tag, "InstPC",      32'(InstPC),      32'(m_ipc));
    cmp(tag, "InstValid",   32'(InstValid),   32'(m_valid));
    cmp(tag, "Done",        32'(Done),        32'(m_done));
    cmp(tag, "CycleCount",  32'(CycleCount),  32'(m_cnt));
  endtask

  // Drive one cycle of inputs, advance DUT and model, check on the falling edge.
  task automatic applyStimulus(input bit st, input bit sl, input bit br,
                               input int tgt, input string tag);
    Start        = st;
    Stall        = sl;
    BranchEn     = br;
    BranchTarget = A'(tgt);
    @(posedge Clk);
    modelStep();
    @(negedge Clk);
    checkOutput(tag);
  endtask

  initial begin
    logic [W-1:0] held_inst;
    int           cnt_before;

    Reset = 1'b0; Start = 0; Stall = 0; BranchEn = 0; BranchTarget = '0;
    fillRom(0);
    modelReset();
    repeat (2) @(negedge Clk);
    checkOutput("reset");
    Reset = 1'b1;

    // Short program ending in a halt word
    rom[0] = 9'h001; rom[1] = 9'h049; rom[2] = 9'h081; rom[3] = 9'h1FF;
    applyStimulus(1, 0, 0, 0, "prog_start");
    applyStimulus(0, 0, 0, 0, "prog_f0");
    cmp("prog_f0", "Inst_const", 32'(Inst), 32'h001);
    cmp("prog_f0", "InstPC_const", 32'(InstPC), 32'd0);
    applyStimulus(0, 0, 0, 0, "prog_f1");
    cmp("prog_f1", "Inst_const", 32'(Inst), 32'h049);
    applyStimulus(0, 0, 0, 0, "prog_f2");
    cmp("prog_f2", "Inst_const", 32'(Inst), 32'h081);
    cmp("prog_f2", "InstPC_const", 32'(InstPC), 32'd2);
    applyStimulus(0, 0, 0, 0, "prog_halt");
    cmp("prog_halt", "Done_const", 32'(Done), 32'd1);
    cmp("prog_halt", "InstValid_const", 32'(InstValid), 32'd0);
    cmp("prog_halt", "InstAddress_const", 32'(InstAddress), 32'd3);
    cmp("prog_halt", "CycleCount_const", 32'(CycleCount), 32'd4);
    applyStimulus(0, 1, 1, 9, "halt_hold");

    // Start from HALT restarts cleanly
    fillRom(0);
    applyStimulus(1, 0, 0, 0, "halt_start");
    cmp("halt_start", "Done_const", 32'(Done), 32'd0);
    cmp("halt_start", "pc_const", 32'(InstAddress), 32'd0);
    cmp("halt_start", "cnt_const", 32'(CycleCount), 32'd0);

    // Advance to PC=7, then stall for three cycles
    repeat (7) applyStimulus(0, 0, 0, 0, "seq");
    held_inst  = Inst;
    cnt_before = int'(CycleCount);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(0, 1, 0, 0, "stall");
      cmp("stall", "pc_const", 32'(InstAddress), 32'd7);
      cmp("stall", "inst_held", 32'(Inst), 32'(held_inst));
      cmp("stall", "cnt_inc", 32'(CycleCount), 32'(cnt_before + k));
    end
    applyStimulus(0, 0, 0, 0, "stall_release");
    cmp("stall_release", "InstPC_const", 32'(InstPC), 32'd7);

    // Start while running is ignored
    applyStimulus(0, 0, 0, 0, "seq9");
    applyStimulus(1, 0, 0, 0, "run_start");
    cmp("run_start", "pc_const", 32'(InstAddress), 32'd10);

    // Branch wins over a simultaneous stall
    applyStimulus(0, 0, 1, 5, "br_to5");
    applyStimulus(0, 1, 1, 10'h200, "br_stall");
    cmp("br_stall", "pc_const", 32'(InstAddress), 32'h200);
    cmp("br_stall", "valid_const", 32'(InstValid), 32'd0);
    applyStimulus(0, 0, 0, 0, "br_fetch");
    cmp("br_fetch", "InstPC_const", 32'(InstPC), 32'h200);
    cmp("br_fetch", "valid_const", 32'(InstValid), 32'd1);

    // Asynchronous reset between edges while running
    Start = 0; Stall = 0; BranchEn = 0;
    @(posedge Clk);
    modelStep();
    #2;
    Reset = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    Start = 1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutput("start_in_reset");
    Start = 0;
    Reset = 1'b1;
    applyStimulus(0, 0, 0, 0, "post_reset_idle");
    applyStimulus(1, 0, 0, 0, "restart");
    applyStimulus(0, 0, 0, 0, "restart_f0");
    cmp("restart_f0", "InstPC_const", 32'(InstPC), 32'd0);

    // Randomized mix with halt words scattered through the ROM
    fillRom(3);
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(99, 0) < 8, $urandom_range(99, 0) < 20,
                    $urandom_range(99, 0) < 15, int'($urandom_range(DEPTH - 1, 0)),
                    "random");
    end

    // Long run with no halt: PC wrap and counter saturation
    fillRom(0);
    Reset = 1'b0;
    modelReset();
    #1;
    checkOutput("reset2");
    @(negedge Clk);
    Reset = 1'b1;
    applyStimulus(1, 0, 0, 0, "long_start");
    for (int i = 1; i <= 70000; i++) begin
      applyStimulus(0, 0, 0, 0, "long");
      if (i == DEPTH) begin
        cmp("wrap", "pc_const", 32'(InstAddress), 32'd0);
        cmp("wrap", "InstPC_const", 32'(InstPC), 32'h3FF);
        cmp("wrap", "valid_const", 32'(InstValid), 32'd1);
      end
    end
    cmp("saturate", "cnt_const", 32'(CycleCount), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter A, default 10, meaning instruction address width; PC range 0..2**A-1.
REQ-002 Parameter W, default 9, meaning instruction word width; halt encoding is all-ones W-bit word.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  single-cycle pulse; begins execution at address 0.
REQ-006 Stall  input  1  downstream hold; freezes PC and fetch register.
REQ-007 BranchEn  input  1  branch taken, resolved by decode this cycle.
REQ-008 BranchTarget  input  A  absolute branch destination.
REQ-009 InstIn  input  W  instruction word returned combinationally by instruction ROM for InstAddress.
REQ-010 InstAddress  output  A  ROM address; equals PC register (combinational from register, no logic on path).
REQ-011 Inst  output  W  registered fetched instruction.
REQ-012 InstPC  output  A  address from which Inst was fetched.
REQ-013 InstValid  output  1  Inst is a valid, correct-path instruction.
REQ-014 Done  output  1  program reached halt; held until Start or reset.
REQ-015 CycleCount  output  16  cycles spent in RUN since last Start.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HALT; reset state IDLE.
REQ-017 IDLE/HALT: Start SHALL set PC=0, InstValid=0, Done=0, CycleCount=0, state RUN next cycle; otherwise all registers hold.
REQ-018 RUN: Start SHALL be ignored.
REQ-019 RUN per-cycle priority SHALL be BranchEn > Stall > halt detect > sequential fetch.
REQ-020 BranchEn=1: PC<=BranchTarget, InstValid<=0 (wrong-path flush), Inst/InstPC hold; Stall ignored this cycle.
REQ-021 Stall=1 (no branch): PC, Inst, InstPC, InstValid SHALL all hold.
REQ-022 Halt detect: InstIn==all-ones with no branch/stall -> PC holds, InstValid<=0, Done<=1, state HALT next cycle; halt word never presented as valid Inst.
REQ-023 Sequential fetch: Inst<=InstIn, InstPC<=PC, InstValid<=1, PC<=PC+1 modulo 2**A (2**A-1 wraps to 0).
REQ-024 Fetch latency SHALL be one cycle: word at address N appears on Inst the cycle after PC==N with no stall.
REQ-025 CycleCount SHALL increment every cycle state==RUN (including stall/branch cycles), saturating at 16'hFFFF; holds in IDLE/HALT.
REQ-026 Branch to a halt address SHALL halt on the following fetch cycle per REQ-022.
REQ-027 InstValid SHALL be 0 in IDLE and HALT.

Reset
REQ-028 Reset low SHALL immediately (asynchronously) force state IDLE, PC=0, Inst=0, InstPC=0, InstValid=0, Done=0, CycleCount=0.
REQ-029 Reset asserted mid-RUN SHALL abort execution; after release block waits in IDLE for Start.
REQ-030 Reset release SHALL take effect at next rising Clk; no Start accepted while Reset low.

Verification
REQ-031 ROM {0:9'h001,1:9'h049,2:9'h081,3:9'h1FF}, Start -> Inst 001/049/081 with InstPC 0/1/2 on consecutive cycles, then Done=1, InstValid=0, InstAddress=3, CycleCount=4.
REQ-032 RUN at PC=5, BranchEn=1, BranchTarget=10'h200, Stall=1 same cycle -> next cycle InstAddress=10'h200, InstValid=0; following cycle InstPC=10'h200, InstValid=1.
REQ-033 Stall high 3 cycles at PC=7 -> InstAddress=7 and Inst unchanged for 3 cycles, CycleCount still +3; release -> InstPC=7 next cycle.
REQ-034 ROM with no halt, A=10 -> PC wraps 10'h3FF->0 with InstValid continuous; run 70000 cycles -> CycleCount=16'hFFFF held.
REQ-035 Reset low asynchronously mid-RUN (between edges) -> outputs zero before next edge; Start after release restarts at address 0.
REQ-036 Start while RUN at PC=9 -> ignored, PC=10 next cycle; Start in HALT -> Done=0, PC=0, CycleCount=0.
